// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between an instruction-fetch and a data requester.
// Data has priority, a grant is held until its address handshake, and responses are routed in order.
module mem_req_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  // instruction-fetch side
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared memory port
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {IDLE, HOLD_INST, HOLD_DATA} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [MAX_OUTSTANDING-1:0] r_id_fifo;   // 0 = inst, 1 = data
  logic [PW-1:0]              r_rd_ptr;
  logic [PW-1:0]              r_wr_ptr;
  logic [CW-1:0]              r_count;

  logic w_sel_inst;
  logic w_sel_data;
  logic w_full;
  logic w_bus_req;
  logic w_handshake;
  logic w_pop;
  logic w_head_is_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign w_full = (r_count == CW'(MAX_OUTSTANDING));

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_sel_inst  = 1'b0;
    w_sel_data  = 1'b0;
    w_state_nxt = r_state;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (data_req)      w_sel_data = 1'b1;
          else if (inst_req) w_sel_inst = 1'b1;
        end
        HOLD_INST: w_sel_inst = 1'b1;
        HOLD_DATA: w_sel_data = 1'b1;
        default: ;
      endcase
    end
    w_bus_req   = ((w_sel_inst && inst_req) || (w_sel_data && data_req)) && !w_full;
    w_handshake = w_bus_req && bus_addr_ok;
    if (r_state == IDLE) begin
      if (w_bus_req && !bus_addr_ok) w_state_nxt = w_sel_data ? HOLD_DATA : HOLD_INST;
    end else if (w_handshake) begin
      w_state_nxt = IDLE;
    end
  end

  assign bus_req   = w_bus_req;
  assign bus_wr    = w_sel_data && data_wr;
  assign bus_size  = w_sel_data ? data_size  : (w_sel_inst ? 2'd2 : 2'd0);
  assign bus_wstrb = w_sel_data ? data_wstrb : 4'd0;
  assign bus_addr  = w_sel_data ? data_addr  : (w_sel_inst ? inst_addr : 32'd0);
  assign bus_wdata = w_sel_data ? data_wdata : 32'd0;

  assign inst_addr_ok = w_handshake && w_sel_inst;
  assign data_addr_ok = w_handshake && w_sel_data;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign w_pop          = bus_data_ok && (r_count != '0) && !reset;
  assign w_head_is_data = r_id_fifo[r_rd_ptr];
  assign inst_data_ok   = w_pop && !w_head_is_data;
  assign data_data_ok   = w_pop && w_head_is_data;
  assign inst_rdata     = bus_rdata;
  assign data_rdata     = bus_rdata;

  // NOTE: sequential state uses non-blocking assignments; the tiny ID FIFO is reset too,
  // since responses after a mid-operation reset must see an empty FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_id_fifo <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_handshake) begin
        r_id_fifo[r_wr_ptr] <= w_sel_data;
        r_wr_ptr            <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_handshake, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: stimulus queues expected grants and responses,
// a negedge monitor pops and compares whenever the DUT handshakes or answers.
module tb_mem_req_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  typedef struct {
    logic        is_data;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_req_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
  endtask

  task automatic exp_inst(input logic [31:0] a);
    req_t r;
    r.is_data = 1'b0; r.wr = 1'b0; r.size = 2'd2; r.wstrb = 4'd0; r.addr = a; r.wdata = '0;
    exp_req_q.push_back(r);
  endtask

  task automatic exp_data(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                          input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    r.is_data = 1'b1; r.wr = wr; r.size = sz; r.wstrb = st; r.addr = a; r.wdata = wd;
    exp_req_q.push_back(r);
  endtask

  task automatic exp_rsp(input logic is_data, input logic [31:0] d);
    rsp_t r;
    r.is_data = is_data; r.rdata = d;
    exp_rsp_q.push_back(r);
  endtask

  task automatic drive_data(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                            input logic [31:0] a, input logic [31:0] wd);
    data_req = 1'b1; data_wr = wr; data_size = sz; data_wstrb = st;
    data_addr = a; data_wdata = wd;
  endtask

  // Monitor: every handshake and every response must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_req && bus_addr_ok) begin
        if (exp_req_q.size() == 0) begin
          check("unexpected_handshake", 32'd1, 32'd0);
        end else begin
          req_t e;
          e = exp_req_q.pop_front();
          check("hs_side_inst_addr_ok", 32'(inst_addr_ok), 32'(!e.is_data));
          check("hs_side_data_addr_ok", 32'(data_addr_ok), 32'(e.is_data));
          check("hs_bus_addr",  bus_addr, e.addr);
          check("hs_bus_wr",    32'(bus_wr), 32'(e.wr));
          check("hs_bus_size",  32'(bus_size), 32'(e.size));
          check("hs_bus_wstrb", 32'(bus_wstrb), 32'(e.wstrb));
          check("hs_bus_wdata", bus_wdata, e.wdata);
        end
      end else begin
        check("no_hs_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      end
      if (inst_data_ok || data_data_ok) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_response", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = exp_rsp_q.pop_front();
          check("rsp_inst_data_ok", 32'(inst_data_ok), 32'(!e.is_data));
          check("rsp_data_data_ok", 32'(data_data_ok), 32'(e.is_data));
          check("rsp_rdata", e.is_data ? data_rdata : inst_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    // Reset: requests and a response pending must all be masked.
    inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    check("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    check("rst_state", 32'(dut.r_state), 32'd0);
    check("rst_count", 32'(dut.r_count), 32'd0);
    next_cycle();

    // Both requesting: data wins first, inst the next cycle; order [data, inst].
    inst_req = 1'b1; inst_addr = 32'h1C00_0100;
    drive_data(1'b1, 2'd2, 4'hF, 32'h0000_0100, 32'hCAFE_F00D);
    bus_addr_ok = 1'b1;
    exp_data(1'b1, 2'd2, 4'hF, 32'h0000_0100, 32'hCAFE_F00D);
    @(negedge clk);
    check("both_data_addr_ok", 32'(data_addr_ok), 32'd1);
    check("both_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    next_cycle();
    data_req = 1'b0;
    exp_inst(32'h1C00_0100);
    @(negedge clk);
    check("both_inst_next", 32'(inst_addr_ok), 32'd1);
    next_cycle();
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'h0D0D_0001; exp_rsp(1'b1, 32'h0D0D_0001);
    next_cycle();
    bus_rdata = 32'h0D0D_0002; exp_rsp(1'b0, 32'h0D0D_0002);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Grant lock: inst held for 3 cycles although data arrives, then data.
    inst_req = 1'b1; inst_addr = 32'h1C00_0200;
    @(negedge clk);
    check("lock_c0_bus_req", 32'(bus_req), 32'd1);
    check("lock_c0_addr", bus_addr, 32'h1C00_0200);
    next_cycle();
    drive_data(1'b1, 2'd0, 4'b0001, 32'h0000_0204, 32'h0000_00AB);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check("lock_hold_addr", bus_addr, 32'h1C00_0200);
      check("lock_hold_wr", 32'(bus_wr), 32'd0);
      next_cycle();
    end
    bus_addr_ok = 1'b1;
    exp_inst(32'h1C00_0200);
    next_cycle();
    inst_req = 1'b0;
    exp_data(1'b1, 2'd0, 4'b0001, 32'h0000_0204, 32'h0000_00AB);
    next_cycle();
    data_req = 1'b0; bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'h1234_0000; exp_rsp(1'b0, 32'h1234_0000);
    next_cycle();
    bus_rdata = 32'h5678_0000; exp_rsp(1'b1, 32'h5678_0000);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Full FIFO: third load blocked until a response pops, and only the cycle after.
    bus_addr_ok = 1'b1;
    drive_data(1'b0, 2'd2, 4'h0, 32'h0000_0300, 32'h0);
    exp_data(1'b0, 2'd2, 4'h0, 32'h0000_0300, 32'h0);
    next_cycle();
    data_addr = 32'h0000_0304;
    exp_data(1'b0, 2'd2, 4'h0, 32'h0000_0304, 32'h0);
    next_cycle();
    data_addr = 32'h0000_0308;
    @(negedge clk);
    check("full_bus_req", 32'(bus_req), 32'd0);
    check("full_data_addr_ok", 32'(data_addr_ok), 32'd0);
    next_cycle();
    bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111; exp_rsp(1'b1, 32'h1111_1111);
    @(negedge clk);
    check("full_pop_no_unblock", 32'(bus_req), 32'd0);
    next_cycle();
    bus_data_ok = 1'b0;
    exp_data(1'b0, 2'd2, 4'h0, 32'h0000_0308, 32'h0);
    @(negedge clk);
    check("full_third_issues", 32'(bus_req), 32'd1);
    next_cycle();
    data_req = 1'b0; bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'h2222_2222; exp_rsp(1'b1, 32'h2222_2222);
    next_cycle();
    bus_rdata = 32'h3333_3333; exp_rsp(1'b1, 32'h3333_3333);
    next_cycle();
    idle_inputs();
    next_cycle();

    // In-order routing; a response in the first handshake cycle has no owner and is dropped.
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_0000;
    exp_inst(32'h1C00_0000);
    @(negedge clk);
    check("same_cycle_drop", 32'({inst_data_ok, data_data_ok}), 32'd0);
    next_cycle();
    inst_req = 1'b0;
    drive_data(1'b0, 2'd2, 4'h0, 32'h0000_0080, 32'h0);
    exp_data(1'b0, 2'd2, 4'h0, 32'h0000_0080, 32'h0);
    bus_rdata = 32'hAAAA_0000; exp_rsp(1'b0, 32'hAAAA_0000);
    next_cycle();
    data_req = 1'b0; bus_addr_ok = 1'b0;
    bus_rdata = 32'hBBBB_0000; exp_rsp(1'b1, 32'hBBBB_0000);
    next_cycle();

    // Protocol error: response with nothing outstanding.
    bus_rdata = 32'hEEEE_EEEE;
    @(negedge clk);
    check("err_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    next_cycle();
    idle_inputs();
    check("err_count", 32'(dut.r_count), 32'd0);
    next_cycle();

    // Mid-operation reset with count = 1 in HOLD_DATA.
    bus_addr_ok = 1'b1;
    drive_data(1'b0, 2'd2, 4'h0, 32'h0000_0500, 32'h0);
    exp_data(1'b0, 2'd2, 4'h0, 32'h0000_0500, 32'h0);
    next_cycle();
    bus_addr_ok = 1'b0; data_addr = 32'h0000_0504; inst_req = 1'b1; inst_addr = 32'h1C00_0500;
    next_cycle();
    check("pre_rst_state", 32'(dut.r_state), 32'd2);
    check("pre_rst_count", 32'(dut.r_count), 32'd1);
    reset = 1'b1; bus_data_ok = 1'b1; bus_addr_ok = 1'b1; bus_rdata = 32'h5555_5555;
    #1;
    check("mid_rst_bus_req", 32'(bus_req), 32'd0);
    check("mid_rst_bus_addr", bus_addr, 32'd0);
    check("mid_rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    check("mid_rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    next_cycle();
    reset = 1'b0;
    inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0;
    check("post_rst_state", 32'(dut.r_state), 32'd0);
    check("post_rst_count", 32'(dut.r_count), 32'd0);
    @(negedge clk);
    check("post_rst_drop", 32'({inst_data_ok, data_data_ok}), 32'd0);
    next_cycle();
    idle_inputs();
    next_cycle();

    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
